hb_wt_time_core: RTL and testbench
==================================

Name: hb_wt_time_core

Overview:
Timekeeping and alarm core of the alarm clock.
- Holds the current time (hour/min/sec) and the alarm setpoint (hour/min).
- Processes the set buttons and drives the ring output.
- Its 6-bit binary outputs feed the display tens/units separators directly: time fields on the NUMBER side, alarm fields on the aNUMBER side, with MODE passed through as the separator's select.

Parameters:
HOUR_MAX, 24, hour modulus; HOUR counts 0..HOUR_MAX-1.
RING_SEC, 60, number of TICK pulses the ring lasts before auto-stop (1..63).

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
TICK  input  1  1 Hz enable, one CLK cycle wide
MODE  input  1  0 = time view/set, 1 = alarm view/set; also passed to the display separator select
SET_H  input  1  one-cycle pulse (debounced upstream): increment hour field of the selected mode
SET_M  input  1  one-cycle pulse: increment minute field of the selected mode
ALM_EN  input  1  alarm armed
STOP  input  1  one-cycle pulse: silence ring
HOUR  output  6  current hour, binary
MIN  output  6  current minute, binary
SEC  output  6  current second, binary
aHOUR  output  6  alarm hour, binary
aMIN  output  6  alarm minute, binary
RING  output  1  alarm sounding

Behaviour:
Reset
- All outputs are 0. FSM is IDLE. Ring counter is 0.
- Reset asserted mid-ring drops RING on the next edge.

Time counting
- On TICK with no set pulse in MODE=0: SEC increments.
- 59->0 carries into MIN; MIN 59->0 carries into HOUR; HOUR HOUR_MAX-1 -> 0.
- All fields update on the same edge; registered, 1-cycle latency.

Time set (MODE=0)
- SET_M: MIN+1 with wrap 59->0, no carry into HOUR; SEC cleared to 0.
- SET_H: HOUR+1 with wrap, no carry.
- A TICK coincident with SET_M or SET_H is dropped; the set wins.
- SET_H and SET_M together: both apply; SEC is cleared.

Alarm set (MODE=1)
- SET_M / SET_H increment aMIN / aHOUR with the same wrap rules.
- Time keeps counting on TICK regardless of set pulses.

Width rules
- Fields never exceed 59 (min/sec) or HOUR_MAX-1 (hour), so the downstream separator always sees a legal value.

Match
- match = ALM_EN && HOUR==aHOUR && MIN==aMIN && SEC==0, evaluated on registered values.

FSM
- IDLE -> RINGING when match. RING=1 from the cycle after the match is registered.
- RINGING:
  - Ring counter counts TICKs.
  - STOP -> ACKED.
  - counter reaches RING_SEC -> ACKED.
  - ALM_EN=0 -> IDLE.
  - RING=1 throughout.
- ACKED:
  - RING=0.
  - Leaves for IDLE when match is false, so no retrigger within the same matching second.
  - ALM_EN=0 -> IDLE.
- STOP and ring-timeout in the same cycle: go to ACKED.
- STOP in IDLE or ACKED: ignored.
- Ring counter clears on entry to RINGING.

Set during ring
- Changing aHOUR/aMIN or the time while RINGING does not stop the ring.

Decomposition:
Shared package
- Constants SEC_MAX=59, MIN_MAX=59, field width 6.
- FSM state encoding IDLE/RINGING/ACKED.
- Shared with the display path so field widths agree.

Sub-module: hb_wt_mod_cnt
- Generic 6-bit modulo counter: inc, load-zero, wrap-out, parameter MAX.
- Instantiated five times (SEC, MIN, HOUR, aMIN, aHOUR).
- Carry chaining and FSM live in the top.

Test Plan:
1. Reset, then 3661 TICKs -> HOUR=1, MIN=1, SEC=1, RING=0.
2. Time 23:59:59, one TICK -> 00:00:00. Time MIN=59 + SET_M -> MIN=0, HOUR unchanged, SEC=0.
3. MODE=1, 7 SET_H + 30 SET_M -> aHOUR=7, aMIN=30, time unaffected. ALM_EN=1, time preset to 07:29:59, one TICK -> RING=1 on the cycle after SEC=0. RING stays high for 60 TICKs, then drops and does not retrigger at 07:30:00.
4. Ringing, STOP pulse -> RING=0 next cycle; FSM stays ACKED until SEC=1, then IDLE. Ringing, ALM_EN=0 -> RING=0, IDLE.
5. TICK and SET_M in the same cycle, MODE=0, SEC=30 -> MIN+1, SEC=0, the tick is lost. Same with MODE=1 -> aMIN+1, SEC=31.
6. RESET asserted while RINGING at 07:30:05 -> next edge: all outputs 0, RING=0, IDLE.

Source files
------------

// File: rtl/hb_wt_time_core_pkg.sv
// Shared constants and ring-state encoding for the alarm clock time core
// and the display path that consumes its 6-bit fields.
package hb_wt_time_core_pkg;
    localparam int FW = 6;
    typedef logic [FW-1:0] field_t;

    localparam field_t SEC_MAX = 6'd59;
    localparam field_t MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_ACKED   = 2'd2
    } ring_st_e;
endpackage

// File: rtl/hb_wt_mod_cnt.sv
// 6-bit modulo counter: counts 0..MAX, wraps to 0, flags the wrapping increment.
module hb_wt_mod_cnt
    import hb_wt_time_core_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   inc_i,
    input  logic   clr_i,
    output field_t val_o,
    output logic   wrap_o
);
    localparam field_t MAX_F = field_t'(MAX);

    field_t val_q, val_d;

    assign wrap_o = inc_i && (val_q == MAX_F);
    assign val_o  = val_q;

    always_comb begin
        val_d = val_q;
        if (clr_i)
            val_d = '0;
        else if (inc_i)
            val_d = wrap_o ? '0 : val_q + 6'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            val_q <= '0;
        else
            val_q <= val_d;
    end
endmodule

// File: rtl/hb_wt_time_core.sv
// Alarm clock time core: time/alarm registers, set-button handling and the
// ring state machine. Outputs feed the display separators directly.
module hb_wt_time_core
    import hb_wt_time_core_pkg::*;
#(
    parameter int HOUR_MAX = 24,
    parameter int RING_SEC = 60
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         TICK,
    input  logic         MODE,
    input  logic         SET_H,
    input  logic         SET_M,
    input  logic         ALM_EN,
    input  logic         STOP,
    output logic [FW-1:0] HOUR,
    output logic [FW-1:0] MIN,
    output logic [FW-1:0] SEC,
    output logic [FW-1:0] aHOUR,
    output logic [FW-1:0] aMIN,
    output logic         RING
);
    localparam field_t RING_LAST = field_t'(RING_SEC - 1);

    logic     tset_h, tset_m, sec_inc, min_inc, hour_inc;
    logic     sec_wrap, min_wrap, hour_wrap, amin_wrap, ahour_wrap;
    logic     match, timeout;
    ring_st_e st_q, st_d;
    field_t   rcnt_q, rcnt_d;
    logic     unused_wraps;

    // A time-set pulse swallows a coincident TICK; carries come only from ticks.
    assign tset_h   = !MODE && SET_H;
    assign tset_m   = !MODE && SET_M;
    assign sec_inc  = TICK && !(tset_h || tset_m);
    assign min_inc  = sec_wrap || tset_m;
    assign hour_inc = (sec_wrap && min_wrap) || tset_h;

    hb_wt_mod_cnt #(.MAX(int'(SEC_MAX))) u_sec (
        .clk_i(CLK), .rst_i(RESET), .inc_i(sec_inc), .clr_i(tset_m),
        .val_o(SEC), .wrap_o(sec_wrap));
    hb_wt_mod_cnt #(.MAX(int'(MIN_MAX))) u_min (
        .clk_i(CLK), .rst_i(RESET), .inc_i(min_inc), .clr_i(1'b0),
        .val_o(MIN), .wrap_o(min_wrap));
    hb_wt_mod_cnt #(.MAX(HOUR_MAX - 1)) u_hour (
        .clk_i(CLK), .rst_i(RESET), .inc_i(hour_inc), .clr_i(1'b0),
        .val_o(HOUR), .wrap_o(hour_wrap));
    hb_wt_mod_cnt #(.MAX(int'(MIN_MAX))) u_amin (
        .clk_i(CLK), .rst_i(RESET), .inc_i(MODE && SET_M), .clr_i(1'b0),
        .val_o(aMIN), .wrap_o(amin_wrap));
    hb_wt_mod_cnt #(.MAX(HOUR_MAX - 1)) u_ahour (
        .clk_i(CLK), .rst_i(RESET), .inc_i(MODE && SET_H), .clr_i(1'b0),
        .val_o(aHOUR), .wrap_o(ahour_wrap));

    assign unused_wraps = hour_wrap ^ amin_wrap ^ ahour_wrap;

    assign match   = ALM_EN && (HOUR == aHOUR) && (MIN == aMIN) && (SEC == '0);
    assign timeout = TICK && (rcnt_q == RING_LAST);
    assign RING    = (st_q == ST_RINGING);

    always_comb begin
        st_d   = st_q;
        rcnt_d = '0;
        case (st_q)
            ST_IDLE:
                if (match) st_d = ST_RINGING;
            ST_RINGING: begin
                rcnt_d = TICK ? rcnt_q + 6'd1 : rcnt_q;
                if (!ALM_EN)
                    st_d = ST_IDLE;
                else if (STOP || timeout)
                    st_d = ST_ACKED;
            end
            // Hold off until the matching second has passed to avoid retrigger.
            ST_ACKED:
                if (!ALM_EN || !match) st_d = ST_IDLE;
            default:
                st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q   <= ST_IDLE;
            rcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            rcnt_q <= rcnt_d;
        end
    end
endmodule

// File: tb/tb_hb_wt_time_core.sv
// Self-checking bench for hb_wt_time_core against a seconds-of-day reference model.
module tb_hb_wt_time_core;
    localparam int HM = 24;
    localparam int RS = 60;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1, TICK = 1'b0, MODE = 1'b0, SET_H = 1'b0, SET_M = 1'b0;
    logic       ALM_EN = 1'b0, STOP = 1'b0;
    logic [5:0] HOUR, MIN, SEC, aHOUR, aMIN;
    logic       RING;

    int pass_cnt = 0;
    int total = 0;

    // reference model state
    int t = 0, ah = 0, am = 0, rt = 0;
    bit ring = 0, acked = 0;

    hb_wt_time_core #(.HOUR_MAX(HM), .RING_SEC(RS)) dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .MODE(MODE), .SET_H(SET_H),
        .SET_M(SET_M), .ALM_EN(ALM_EN), .STOP(STOP), .HOUR(HOUR), .MIN(MIN),
        .SEC(SEC), .aHOUR(aHOUR), .aMIN(aMIN), .RING(RING));

    always #5 CLK = ~CLK;

    function automatic logic [30:0] exp_v();
        return {6'(t / 3600), 6'((t / 60) % 60), 6'(t % 60), 6'(ah), 6'(am), 1'(ring)};
    endfunction

    function automatic logic [30:0] got_v();
        return {HOUR, MIN, SEC, aHOUR, aMIN, RING};
    endfunction

    task automatic model_step(input bit tk, sh, sm, sp, rs);
        int h, m, s;
        bit match;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        match = ALM_EN && h == ah && m == am && s == 0;
        if (rs) begin
            t = 0; ah = 0; am = 0; rt = 0; ring = 0; acked = 0;
            return;
        end
        if (ring) begin
            if (!ALM_EN) ring = 0;
            else if (sp || (tk && rt + 1 == RS)) begin ring = 0; acked = 1; end
            else if (tk) rt++;
        end else if (acked) begin
            if (!ALM_EN || !match) acked = 0;
        end else if (match) begin
            ring = 1; rt = 0;
        end
        if (!MODE && (sh || sm)) begin
            if (sm) begin m = (m + 1) % 60; s = 0; end
            if (sh) h = (h + 1) % HM;
            t = h * 3600 + m * 60 + s;
        end else begin
            if (MODE && sm) am = (am + 1) % 60;
            if (MODE && sh) ah = (ah + 1) % HM;
            if (tk) t = (t + 1) % (HM * 3600);
        end
    endtask

    task automatic cyc(input bit tk, sh, sm, sp, rs);
        TICK = tk; SET_H = sh; SET_M = sm; STOP = sp; RESET = rs;
        @(posedge CLK);
        model_step(tk, sh, sm, sp, rs);
        @(negedge CLK);
        TICK = 0; SET_H = 0; SET_M = 0; STOP = 0; RESET = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    // Bring time to 07:29:59 with the alarm disarmed.
    task automatic preset_072959();
        int nh, nm;
        MODE = 0; ALM_EN = 0;
        nh = (7 - t / 3600 + HM) % HM;
        nm = (29 - (t / 60) % 60 + 59) % 60 + 1;
        for (int i = 0; i < nh; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < nm; i++) cyc(0, 0, 1, 0, 0);
        ticks(59);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        total++;
        if (got_v() !== 31'd0) $display("FAIL reset_zero got %h exp 0", got_v());
        else pass_cnt++;
        ticks(3661);
        total++;
        if ({HOUR, MIN, SEC, RING} !== {6'd1, 6'd1, 6'd1, 1'b0})
            $display("FAIL count_3661 got %0d:%0d:%0d ring %b exp 1:1:1 ring 0", HOUR, MIN, SEC, RING);
        else pass_cnt++;
        total++;
        if (got_v() !== exp_v()) $display("FAIL count_model got %h exp %h", got_v(), exp_v());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        cyc(0, 0, 0, 0, 1);
        ALM_EN = 0; MODE = 0;
        for (int i = 0; i < 23; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0, 0);
        ticks(59);
        total++;
        if ({HOUR, MIN, SEC} !== {6'd23, 6'd59, 6'd59})
            $display("FAIL preset_235959 got %0d:%0d:%0d exp 23:59:59", HOUR, MIN, SEC);
        else pass_cnt++;
        ticks(1);
        total++;
        if ({HOUR, MIN, SEC} !== 18'd0)
            $display("FAIL day_wrap got %0d:%0d:%0d exp 0:0:0", HOUR, MIN, SEC);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0, 0);
        ticks(7);
        cyc(0, 0, 1, 0, 0);
        total++;
        if ({HOUR, MIN, SEC} !== {6'd5, 6'd0, 6'd0})
            $display("FAIL setm_wrap got %0d:%0d:%0d exp 5:0:0", HOUR, MIN, SEC);
        else pass_cnt++;
        cyc(0, 1, 1, 0, 0);
        total++;
        if ({HOUR, MIN, SEC} !== {6'd6, 6'd1, 6'd0})
            $display("FAIL set_both got %0d:%0d:%0d exp 6:1:0", HOUR, MIN, SEC);
        else pass_cnt++;
    endtask

    task automatic test_alarm_timeout();
        cyc(0, 0, 0, 0, 1);
        ALM_EN = 0; MODE = 1;
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 0, 1, 0, 0);
        total++;
        if ({aHOUR, aMIN, HOUR, MIN, SEC} !== {6'd7, 6'd30, 6'd0, 6'd0, 6'd37})
            $display("FAIL alarm_set got a%0d:%0d t%0d:%0d:%0d exp a7:30 t0:0:37",
                     aHOUR, aMIN, HOUR, MIN, SEC);
        else pass_cnt++;
        preset_072959();
        ALM_EN = 1;
        ticks(1);
        total++;
        if ({SEC, RING} !== {6'd0, 1'b0}) $display("FAIL match_edge got sec %0d ring %b exp 0 0", SEC, RING);
        else pass_cnt++;
        cyc(0, 0, 0, 0, 0);
        total++;
        if (RING !== 1'b1) $display("FAIL ring_start got %b exp 1", RING);
        else pass_cnt++;
        for (int i = 0; i < RS; i++) begin
            ticks(1);
            total++;
            if (RING !== (i < RS - 1)) $display("FAIL ring_hold[%0d] got %b exp %b", i, RING, i < RS - 1);
            else pass_cnt++;
        end
        ticks(3);
        total++;
        if (RING !== 1'b0 || got_v() !== exp_v()) $display("FAIL ring_timeout got %h exp %h", got_v(), exp_v());
        else pass_cnt++;
    endtask

    task automatic test_stop_disarm();
        preset_072959();
        ALM_EN = 1;
        ticks(1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        total++;
        if (RING !== 1'b0) $display("FAIL stop got %b exp 0", RING);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        total++;
        if ({SEC, RING} !== {6'd0, 1'b0}) $display("FAIL no_retrigger got sec %0d ring %b exp 0 0", SEC, RING);
        else pass_cnt++;
        ticks(2);
        total++;
        if (got_v() !== exp_v()) $display("FAIL acked_exit got %h exp %h", got_v(), exp_v());
        else pass_cnt++;
        preset_072959();
        ALM_EN = 1;
        ticks(1);
        cyc(0, 0, 0, 0, 0);
        total++;
        if (RING !== 1'b1) $display("FAIL ring_again got %b exp 1", RING);
        else pass_cnt++;
        ALM_EN = 0;
        cyc(0, 0, 0, 0, 0);
        total++;
        if (RING !== 1'b0) $display("FAIL disarm got %b exp 0", RING);
        else pass_cnt++;
    endtask

    task automatic test_set_vs_tick();
        cyc(0, 0, 0, 0, 1);
        ALM_EN = 0; MODE = 0;
        ticks(30);
        cyc(1, 0, 1, 0, 0);
        total++;
        if ({MIN, SEC} !== {6'd1, 6'd0}) $display("FAIL tick_drop got %0d:%0d exp 1:0", MIN, SEC);
        else pass_cnt++;
        ticks(30);
        MODE = 1;
        cyc(1, 0, 1, 0, 0);
        total++;
        if ({aMIN, MIN, SEC} !== {6'd1, 6'd1, 6'd31})
            $display("FAIL alarm_mode_tick got a%0d t%0d:%0d exp a1 t1:31", aMIN, MIN, SEC);
        else pass_cnt++;
    endtask

    task automatic test_reset_ring();
        cyc(0, 0, 0, 0, 1);
        MODE = 1; ALM_EN = 0;
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0, 0);
        preset_072959();
        ALM_EN = 1;
        ticks(1);
        cyc(0, 0, 0, 0, 0);
        ticks(5);
        total++;
        if ({HOUR, MIN, SEC, RING} !== {6'd7, 6'd30, 6'd5, 1'b1})
            $display("FAIL ring_073005 got %0d:%0d:%0d ring %b exp 7:30:5 ring 1", HOUR, MIN, SEC, RING);
        else pass_cnt++;
        ALM_EN = 0;
        cyc(0, 0, 0, 0, 1);
        total++;
        if (got_v() !== 31'd0) $display("FAIL reset_mid_ring got %h exp 0", got_v());
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            MODE   = ($urandom_range(0, 3) == 0);
            ALM_EN = ($urandom_range(0, 15) != 0);
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0,
                $urandom_range(0, 30) == 0, $urandom_range(0, 400) == 0);
            total++;
            if (got_v() !== exp_v()) $display("FAIL random[%0d] got %h exp %h", i, got_v(), exp_v());
            else pass_cnt++;
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_wrap();
        test_alarm_timeout();
        test_stop_disarm();
        test_set_vs_tick();
        test_reset_ring();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
